gpio_in_debounce: RTL
=====================

Name: gpio_in_debounce

Overview:
- Sits directly downstream of the 2-flop input synchronizer in the utils library.
- Takes already-synchronized external input bits (GPIO, buttons, external IRQ lines) and filters each bit with a per-bit stability counter.
- Produces clean debounced levels, single-cycle rise/fall event pulses, and a per-bit sticky pending register that drives one combined interrupt to the core.
- Inputs must come from the synchronizer; this block adds no metastability protection of its own.

Parameters:
- DW, 8: number of independent input bits.
- CW, 16: width of each per-bit debounce counter and of the thresh input.
- RST_VAL, 0 (DW bits): reset value of the debounced level register.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-low (0 = reset asserted, sampled on clk rising edge).
- din  input  DW  synchronized raw inputs.
- en  input  1  filter enable; 0 freezes filtering.
- thresh  input  CW  number of consecutive differing samples required to accept a new level; 0 is treated as 1.
- edge_sel  input  DW  per-bit pending source: 1 = rising event sets pending, 0 = falling event sets pending.
- ie  input  DW  per-bit interrupt enable.
- clr_vld  input  1  pending-clear strobe.
- clr_mask  input  DW  bits to clear when clr_vld = 1.
- stable  output  DW  debounced level.
- rise_pls  output  DW  one-cycle pulse on an accepted 0->1 transition.
- fall_pls  output  DW  one-cycle pulse on an accepted 1->0 transition.
- pend  output  DW  sticky pending bits.
- irq  output  1  |(pend & ie), combinational from registers.

Behaviour:
- Reset (rst = 0 at an edge):
  - stable = RST_VAL.
  - All counters = 0.
  - rise_pls = fall_pls = 0.
  - pend = 0, so irq = 0.
  - Reset applied mid-count discards all partial counts; no pulse is generated by the reset itself.
- Effective threshold: T = (thresh == 0) ? 1 : thresh. T is re-evaluated every cycle; there is no latching.
- Per bit i, each edge with en = 1:
  - din[i] == stable[i]: cnt[i] <= 0. This removes any glitch shorter than T cycles.
  - din[i] != stable[i] and cnt[i] + 1 >= T:
    - stable[i] <= din[i], cnt[i] <= 0.
    - rise_pls[i] or fall_pls[i] <= 1 according to the new level, registered on the same edge as stable changes.
  - Otherwise: cnt[i] <= cnt[i] + 1, saturating at all-ones; no wrap.
- Latency: if din flips before edge k and stays flipped, stable and the event pulse update at edge k+T-1.
  - T = 1 gives 1 cycle of latency.
  - T = 4 updates at edge k+3.
- Pulses are 1 cycle wide. They are cleared on every edge that is not an accepted transition.
- Lowering thresh mid-count: if cnt[i] + 1 >= new T, the transition is accepted at the next edge where din still differs.
- en = 0:
  - Counters forced to 0; stable holds.
  - No pulses generated; rise_pls and fall_pls return to 0 on the next edge.
  - pend is retained and clr_vld remains functional.
- Pending, per bit:
  - set = edge_sel[i] ? rise_pls_next[i] : fall_pls_next[i], i.e. the same edge the pulse is registered.
  - clr = clr_vld & clr_mask[i].
  - Set and clear on the same edge: set wins, and pend[i] = 1.
  - Otherwise pend[i] <= clr ? 0 : pend[i].
- Pending is sticky regardless of ie; ie only gates irq.
- Bits are fully independent. Simultaneous events on several bits each set their own pend bit.

Test Plan:
- Reset, RST_VAL = 0: hold rst = 0 for 3 cycles with din = 8'hFF → stable = 0, pend = 0, irq = 0, no pulses. Release rst with thresh = 4 and din = 8'hFF → stable = 8'hFF exactly 4 edges later, rise_pls = 8'hFF for exactly one cycle.
- Glitch rejection: thresh = 5, din[0] high for 4 cycles then low → stable[0] stays 0, rise_pls[0] never asserts, cnt returns to 0. A subsequent 5-cycle high → stable[0] = 1 at the 5th edge.
- thresh = 0 and thresh = 1: din[2] toggles every 2 cycles → stable[2] follows with 1-cycle latency, alternating rise and fall pulses.
- Pending/irq: edge_sel[3] = 0, ie[3] = 1, accepted 1->0 on bit 3 → pend[3] = 1, irq = 1. Pulse clr_vld with clr_mask = 8'h08 → pend[3] = 0, irq = 0. Repeat with clr_vld on the same edge as the new event → pend[3] remains 1.
- ie gating: bit 5 event with ie[5] = 0 → pend[5] = 1, irq = 0. Set ie[5] = 1 → irq = 1 in the same cycle.
- en and reset mid-operation: thresh = 10, din[1] differing for 6 cycles, then en = 0 for 3 cycles, then en = 1 → stable[1] updates 10 edges after en rises, not 4. Separately, assert rst at count 8 → no pulse, stable = RST_VAL.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// gpio_in_debounce: per-bit debounce filter for already-synchronized inputs.
// Each bit counts consecutive samples that differ from its accepted level.
// When the count reaches the threshold, the bit takes the new level and
// emits a one-cycle rise/fall pulse. Pulses set sticky pending bits, and the
// pending bits are combined into one interrupt.

// One filter lane. Every bit is independent, so the top instantiates DW of these.
module gpio_in_debounce_lane #(
   parameter int   CW      = 16,
   parameter logic RST_VAL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          din,
   input  logic          en,
   input  logic [CW-1:0] t_eff,
   input  logic          edge_sel,
   input  logic          clr,
   output logic          stable,
   output logic          rise_pls,
   output logic          fall_pls,
   output logic          pend
);

   logic [CW-1:0] cnt, cnt_nxt;
   logic [CW:0]   cnt_inc;
   logic          stable_nxt, rise_nxt, fall_nxt, pend_nxt, accept, diff, set;

   // next-state: count differing samples, accept at threshold, derive pulses/pending
   always_comb begin
      cnt_inc    = {1'b0, cnt} + {{CW{1'b0}}, 1'b1};
      diff       = (din != stable);
      // compare one bit wider so cnt+1 never wraps before the compare
      accept     = en & diff & (cnt_inc >= {1'b0, t_eff});
      stable_nxt = accept ? din : stable;
      rise_nxt   = accept & din;
      fall_nxt   = accept & ~din;
      if (!en || !diff || accept)
         cnt_nxt = '0;
      else if (cnt == '1)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt_inc[CW-1:0];
      // a new event wins over a clear that lands on the same edge
      set        = edge_sel ? rise_nxt : fall_nxt;
      pend_nxt   = set | (pend & ~clr);
   end

   // lane state register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         stable   <= RST_VAL;
         cnt      <= '0;
         rise_pls <= 1'b0;
         fall_pls <= 1'b0;
         pend     <= 1'b0;
      end else begin
         stable   <= stable_nxt;
         cnt      <= cnt_nxt;
         rise_pls <= rise_nxt;
         fall_pls <= fall_nxt;
         pend     <= pend_nxt;
      end
   end

endmodule

module gpio_in_debounce #(
   parameter int          DW      = 8,
   parameter int          CW      = 16,
   parameter logic [DW-1:0] RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] din,
   input  logic          en,
   input  logic [CW-1:0] thresh,
   input  logic [DW-1:0] edge_sel,
   input  logic [DW-1:0] ie,
   input  logic          clr_vld,
   input  logic [DW-1:0] clr_mask,
   output logic [DW-1:0] stable,
   output logic [DW-1:0] rise_pls,
   output logic [DW-1:0] fall_pls,
   output logic [DW-1:0] pend,
   output logic          irq
);

   logic [CW-1:0] t_eff;
   logic [DW-1:0] clr;

   // shared controls: zero threshold behaves as one, clear strobe gated per bit
   always_comb begin
      t_eff = (thresh == '0) ? {{(CW-1){1'b0}}, 1'b1} : thresh;
      clr   = clr_vld ? clr_mask : '0;
      irq   = |(pend & ie);
   end

   for (genvar i = 0; i < DW; i++) begin : g_lane
      gpio_in_debounce_lane #(
         .CW      (CW),
         .RST_VAL (RST_VAL[i])
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .din      (din[i]),
         .en       (en),
         .t_eff    (t_eff),
         .edge_sel (edge_sel[i]),
         .clr      (clr[i]),
         .stable   (stable[i]),
         .rise_pls (rise_pls[i]),
         .fall_pls (fall_pls[i]),
         .pend     (pend[i])
      );
   end

endmodule
